// File: rtl/demux_lane_scheduler.sv
// demux_lane_scheduler: steers a valid/ready word stream into four registered
// output lanes, round-robin with timeout skipping or software-directed.
module demux_lane_scheduler #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] In,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Mode,
    input  logic [1:0]       DestSel,
    input  logic [3:0]       LaneReady,
    output logic [WIDTH-1:0] Aout,
    output logic [WIDTH-1:0] Bout,
    output logic [WIDTH-1:0] Cout,
    output logic [WIDTH-1:0] Dout,
    output logic [3:0]       LaneValid,
    output logic [1:0]       Sel,
    output logic             Enable,
    output logic [7:0]       SkipCount,
    output logic             Busy
);

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [1:0]       r_sel;
    logic [7:0]       r_skip;
    logic [3:0]       r_valid;
    logic [WIDTH-1:0] r_lane [4];

    logic [1:0] w_t;
    logic       w_ready;
    logic       w_acc;

    assign w_t     = Mode ? DestSel : r_sel;
    assign w_ready = ~reset & (~r_valid[w_t] | LaneReady[w_t]);
    assign w_acc   = InValid & w_ready;

    assign InReady   = w_ready;
    assign Enable    = w_acc;
    assign LaneValid = r_valid;
    assign Sel       = r_sel;
    assign SkipCount = r_skip;
    assign Busy      = |r_valid;

    assign Aout = r_valid[0] ? r_lane[0] : '0;
    assign Bout = r_valid[1] ? r_lane[1] : '0;
    assign Cout = r_valid[2] ? r_lane[2] : '0;
    assign Dout = r_valid[3] ? r_lane[3] : '0;

    // A refill of a draining lane keeps it valid with the new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < 4; i++) begin
                r_lane[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc && (w_t == 2'(i))) begin
                    r_lane[i]  <= In;
                    r_valid[i] <= 1'b1;
                end else if (r_valid[i] && LaneReady[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // The first blocked cycle is spent in IDLE, so WAIT starts counting at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_skip  <= '0;
        end else begin
            if (w_acc && !Mode) begin
                r_sel <= r_sel + 2'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (InValid && !w_ready && !Mode) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (w_acc || !InValid || Mode) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= LP_LAST) begin
                        r_sel <= r_sel + 2'd1;
                        r_cnt <= '0;
                        if (r_skip != 8'hFF) begin
                            r_skip <= r_skip + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
